// File: rtl/regfile_piso_reader_if.sv
// Bus bundle for regfile_piso_reader: burst command, register-file read port,
// serial output stream and status.
interface regfile_piso_reader_if;
   logic       start;
   logic [2:0] start_addr;
   logic [2:0] count;
   logic [2:0] rf_addr;
   logic [7:0] rf_data;
   logic       ser_en;
   logic       ser_out;
   logic       ser_valid;
   logic       ser_last;
   logic       busy;
   logic       done;

   modport master (
      output start, start_addr, count, rf_data, ser_en,
      input  rf_addr, ser_out, ser_valid, ser_last, busy, done
   );

   modport slave (
      input  start, start_addr, count, rf_data, ser_en,
      output rf_addr, ser_out, ser_valid, ser_last, busy, done
   );
endinterface

// File: rtl/regfile_piso_reader.sv
// Reads a burst of consecutive register-file bytes and streams them out
// serially, one bit per downstream ser_en, with one load cycle per byte.
module regfile_piso_reader #(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   regfile_piso_reader_if.slave  bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0] state;
   logic [2:0] cur_addr;
   logic [3:0] bytes_left;
   logic [2:0] bit_cnt;
   logic [7:0] shreg;

   logic       in_shift;
   logic       consume;
   logic       last_bit_of_byte;

   assign in_shift         = (state == ST_SHIFT);
   assign consume          = in_shift && bus.ser_en;
   assign last_bit_of_byte = (bit_cnt == 3'd7);

   // NOTE: every register here is written with non-blocking assignments so all
   // state moves together on the edge; blocking would leak new values into
   // later statements of the same block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cur_addr   <= '0;
         bytes_left <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  cur_addr   <= bus.start_addr;
                  bytes_left <= (bus.count == 3'd0) ? 4'd8 : {1'b0, bus.count};
                  state      <= ST_LOAD;
               end
            end

            ST_LOAD: begin
               shreg   <= bus.rf_data;
               bit_cnt <= '0;
               state   <= ST_SHIFT;
            end

            ST_SHIFT: begin
               // Without ser_en everything holds, so the visible bit stays put.
               if (consume) begin
                  shreg   <= MSB_FIRST ? {shreg[6:0], 1'b0} : {1'b0, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (last_bit_of_byte) begin
                     bytes_left <= bytes_left - 4'd1;
                     if (bytes_left == 4'd1) begin
                        state <= ST_DONE;
                     end else begin
                        cur_addr <= cur_addr + 3'd1;
                        state    <= ST_LOAD;
                     end
                  end
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // NOTE: each output gets a default before the conditional logic so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      bus.rf_addr   = cur_addr;
      bus.ser_valid = 1'b0;
      bus.ser_out   = 1'b0;
      bus.ser_last  = 1'b0;
      bus.busy      = (state != ST_IDLE);
      bus.done      = (state == ST_DONE);
      if (in_shift) begin
         bus.ser_valid = 1'b1;
         bus.ser_out   = MSB_FIRST ? shreg[7] : shreg[0];
         bus.ser_last  = last_bit_of_byte && (bytes_left == 4'd1);
      end
   end

endmodule

// File: tb/tb_regfile_piso_reader.sv
// Self-checking bench: MSB-first and LSB-first instances run in lockstep against
// a behavioural register file, with a scoreboard of expected serial bits.
module tb_regfile_piso_reader;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   regfile_piso_reader_if bus_m ();
   regfile_piso_reader_if bus_l ();

   regfile_piso_reader #(.MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst_n(rst_n), .bus(bus_m));
   regfile_piso_reader #(.MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(bus_l));

   function automatic logic [7:0] rf_val(input logic [2:0] a);
      return (a == 3'd0) ? 8'h0D : {5'b00010, a};
   endfunction

   assign bus_m.rf_data    = rf_val(bus_m.rf_addr);
   assign bus_l.rf_data    = rf_val(bus_l.rf_addr);
   assign bus_l.start      = bus_m.start;
   assign bus_l.start_addr = bus_m.start_addr;
   assign bus_l.count      = bus_m.count;
   assign bus_l.ser_en     = bus_m.ser_en;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_m"}, {bus_m.rf_addr, bus_m.ser_out, bus_m.ser_valid, bus_m.ser_last,
                          bus_m.busy, bus_m.done}, 32'h0);
      check({tag, "_l"}, {bus_l.rf_addr, bus_l.ser_out, bus_l.ser_valid, bus_l.ser_last,
                          bus_l.busy, bus_l.done}, 32'h0);
   endtask

   // Scoreboard: {bit, last} pairs per stream, plus expected read addresses.
   logic [1:0] q_m[$];
   logic [1:0] q_l[$];
   logic [2:0] q_a[$];

   task automatic run_burst(input logic [2:0] sa, input logic [2:0] cnt, input bit rnd,
                            input bit poke, output int nbits,
                            output logic [7:0] first_m, output logic [7:0] first_l);
      int         n;
      int         gap;
      bit         prev_hold;
      logic       prev_out;
      bit         fin;
      bit         poked;
      logic       en;
      logic [7:0] d;
      logic [2:0] a;
      logic [1:0] e;
      n = (cnt == 3'd0) ? 8 : int'(cnt);
      q_m.delete(); q_l.delete(); q_a.delete();
      for (int b = 0; b < n; b++) begin
         a = sa + 3'(b);
         d = rf_val(a);
         q_a.push_back(a);
         for (int i = 0; i < 8; i++) begin
            q_m.push_back({d[7 - i], (b == n - 1) && (i == 7)});
            q_l.push_back({d[i],     (b == n - 1) && (i == 7)});
         end
      end
      nbits = 0; gap = 0; prev_hold = 0; prev_out = 0; fin = 0; poked = 0;
      first_m = '0; first_l = '0;

      @(negedge clk);
      bus_m.start = 1'b1; bus_m.start_addr = sa; bus_m.count = cnt; bus_m.ser_en = 1'b1;
      for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
         @(negedge clk);
         bus_m.start = 1'b0;
         if (bus_m.done) begin
            check("done_busy", bus_m.busy, 1'b1);
            check("sb_empty", q_m.size() + q_l.size() + q_a.size(), 0);
            @(negedge clk);
            check("done_one_cycle", bus_m.done, 1'b0);
            check("busy_after_done", bus_m.busy, 1'b0);
            fin = 1;
         end else if (!bus_m.ser_valid) begin
            check("quiet_out", {bus_m.ser_out, bus_m.ser_last, bus_l.ser_out, bus_l.ser_last}, 0);
            if (bus_m.busy) begin
               if (q_a.size() == 0) check("rf_addr_extra_load", q_a.size(), 1);
               else check("rf_addr", bus_m.rf_addr, q_a.pop_front());
               gap++;
            end
            prev_hold = 0;
         end else begin
            if (gap != 0) begin
               check("load_bubble", gap, 1);
               gap = 0;
            end
            if (prev_hold) check("hold_stable", bus_m.ser_out, prev_out);
            en = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus_m.ser_en = en;
            if (en) begin
               if (q_m.size() == 0) begin
                  check("extra_bit", q_m.size(), 1);
               end else begin
                  e = q_m.pop_front();
                  check("bit_msb", {bus_m.ser_out, bus_m.ser_last}, e);
                  e = q_l.pop_front();
                  check("bit_lsb", {bus_l.ser_out, bus_l.ser_last}, e);
               end
               if (nbits < 8) begin
                  first_m = {first_m[6:0], bus_m.ser_out};
                  first_l = {bus_l.ser_out, first_l[7:1]};
               end
               nbits++;
            end
            prev_hold = !en;
            prev_out  = bus_m.ser_out;
            if (poke && nbits == 3 && !poked) begin
               bus_m.start = 1'b1; bus_m.start_addr = 3'd5; bus_m.count = 3'd2;
               poked = 1;
            end
         end
      end
      bus_m.ser_en = 1'b1;
      check("burst_finished", fin, 1'b1);
   endtask

   typedef struct {
      logic [2:0] sa;
      logic [2:0] cnt;
      bit         rnd;
      bit         poke;
      int         exp_nbits;
      logic [7:0] exp_first;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int         nb;
      logic [7:0] fm;
      logic [7:0] fl;
      int         consumed;
      bit         reached;

      vecs[0] = '{3'd0, 3'd1, 1'b0, 1'b0,  8, 8'h0D};
      vecs[1] = '{3'd6, 3'd3, 1'b0, 1'b0, 24, 8'h16};
      vecs[2] = '{3'd0, 3'd0, 1'b0, 1'b0, 64, 8'h0D};
      vecs[3] = '{3'd0, 3'd1, 1'b1, 1'b0,  8, 8'h0D};
      vecs[4] = '{3'd3, 3'd2, 1'b1, 1'b1, 16, 8'h13};
      vecs[5] = '{3'd7, 3'd0, 1'b1, 1'b0, 64, 8'h17};
      vecs[6] = '{3'd5, 3'd1, 1'b0, 1'b1,  8, 8'h15};

      rst_n = 1'b0;
      bus_m.start = 1'b0; bus_m.start_addr = '0; bus_m.count = '0; bus_m.ser_en = 1'b0;
      #1;
      check_outputs_zero("reset_state");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_outputs_zero("idle_after_reset");

      for (int v = 0; v < 7; v++) begin
         run_burst(vecs[v].sa, vecs[v].cnt, vecs[v].rnd, vecs[v].poke, nb, fm, fl);
         check("nbits", nb, vecs[v].exp_nbits);
         check("first_byte_msb", fm, vecs[v].exp_first);
         check("first_byte_lsb", fl, vecs[v].exp_first);
      end

      // Abort a 3-byte burst once bit 3 of byte 2 has gone out.
      consumed = 0; reached = 0;
      @(negedge clk);
      bus_m.start = 1'b1; bus_m.start_addr = 3'd0; bus_m.count = 3'd3; bus_m.ser_en = 1'b1;
      for (int cyc = 0; cyc < 200 && !reached; cyc++) begin
         @(negedge clk);
         bus_m.start = 1'b0;
         if (consumed == 12) reached = 1;
         else if (bus_m.ser_valid) consumed++;
      end
      check("abort_point_reached", reached, 1'b1);
      check("busy_before_abort", bus_m.busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("async_reset");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("no_done_in_reset", {bus_m.done, bus_l.done}, 2'b00);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_after_abort", {bus_m.busy, bus_m.done, bus_m.ser_valid}, 3'b000);
      end

      run_burst(3'd1, 3'd2, 1'b0, 1'b0, nb, fm, fl);
      check("post_abort_nbits", nb, 16);
      check("post_abort_first_msb", fm, 8'h11);
      check("post_abort_first_lsb", fl, 8'h11);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_piso_reader.md
REGFILE_PISO_READER -- requirements
Module: regfile_piso_reader

Interface
REQ-001 The block SHALL have parameter MSB_FIRST, default 1; 1 = bit 7 of each byte shifted first, 0 = bit 0 first.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: burst request, sampled only in IDLE.
REQ-005 The block SHALL have port start_addr, input, 3 bits: first register address of the burst.
REQ-006 The block SHALL have port count, input, 3 bits: number of bytes in the burst; 0 encodes 8.
REQ-007 The block SHALL have port rf_addr, output, 3 bits: read address driven to the register-file read port.
REQ-008 The block SHALL have port rf_data, input, 8 bits: combinational read data returned from the register file for rf_addr.
REQ-009 The block SHALL have port ser_en, input, 1 bit: downstream shift enable; the current bit is consumed on a rising edge with ser_en=1.
REQ-010 The block SHALL have port ser_out, output, 1 bit: serial data.
REQ-011 The block SHALL have port ser_valid, output, 1 bit: ser_out carries a valid bit.
REQ-012 The block SHALL have port ser_last, output, 1 bit: current bit is the final bit of the burst.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse at burst completion.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, SHIFT and DONE, all registered.
REQ-016 In IDLE with start=1, the block SHALL latch start_addr into cur_addr, latch count (0 mapped to 8) into a 4-bit bytes_left, and enter LOAD.
REQ-017 The block SHALL ignore start in every state other than IDLE.
REQ-018 In LOAD, the block SHALL drive rf_addr=cur_addr, capture rf_data into an 8-bit shift register on the closing edge, clear the 3-bit bit_cnt, and enter SHIFT.
REQ-019 In SHIFT, the block SHALL hold ser_valid=1, with ser_out = shreg[7] (MSB_FIRST=1) or shreg[0] (MSB_FIRST=0).
REQ-020 In SHIFT with ser_en=0, the block SHALL hold shreg, bit_cnt and ser_out unchanged, with no bit lost or repeated.
REQ-021 In SHIFT with ser_en=1, the block SHALL shift shreg by one toward the output end, fill the vacated bit with 0, and increment bit_cnt.
REQ-022 On a consumed bit with bit_cnt=7, the block SHALL decrement bytes_left; if the result is 0 it SHALL enter DONE, otherwise it SHALL set cur_addr = cur_addr+1 modulo 8 (7 wraps to 0) and enter LOAD.
REQ-023 The block SHALL drive ser_last=1 only in SHIFT with bit_cnt=7 and bytes_left=1.
REQ-024 In DONE, the block SHALL assert done=1 for exactly one cycle and then enter IDLE; start is not accepted in DONE.
REQ-025 Latency SHALL be: start accepted at edge N, first bit valid in the cycle after edge N+1, and one LOAD bubble (ser_valid=0) between consecutive bytes.
REQ-026 In IDLE, LOAD and DONE, ser_valid, ser_out and ser_last SHALL be 0; rf_addr SHALL equal cur_addr in all states.
REQ-027 The block SHALL never write the register file, and rf_data SHALL be sampled only in LOAD.

Reset
REQ-028 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, cur_addr=0, bytes_left=0, bit_cnt=0 and shreg=0, giving outputs rf_addr=0, ser_out=0, ser_valid=0, ser_last=0, busy=0 and done=0.
REQ-029 Reset asserted mid-burst SHALL abort the burst with no done pulse; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-030 Register-file model: reg0 reads 0x0D, regN reads 0x10+N for N=1..7; start_addr=0, count=1, ser_en=1, MSB_FIRST=1 -> ser_out 0,0,0,0,1,1,0,1; ser_last on the 8th bit; done one cycle later; busy low after.
REQ-031 start_addr=6, count=3 -> rf_addr sequence 6,7,0; bytes 0x16, 0x17, 0x0D; one LOAD bubble between bytes.
REQ-032 count=0 -> 8 bytes from start_addr=0, 64 bits total, ser_last only on bit 64.
REQ-033 ser_en toggled randomly during SHIFT -> serial stream identical to the ser_en=1 run; ser_out stable whenever ser_en=0.
REQ-034 start pulsed while busy -> ignored, burst unchanged; rst_n pulsed low after bit 3 of byte 2 -> outputs 0 immediately, no done pulse, next start runs normally.
REQ-035 MSB_FIRST=0, reg0 -> ser_out 1,0,1,1,0,0,0,0.
